dso_capture_ctrl: RTL and testbench
===================================

# dso_capture_ctrl

Capture controller for the scope's 512-sample sample memory. Drives the RAM512 port as its initiator. During capture it writes incoming 8-bit ADC samples into the RAM as a circular buffer, honouring a programmable pre/post-trigger split. After capture it reads the 512 stored samples back, oldest first, for the host/UART dump path.

## Interface
- No parameters: depth fixed at 512 and width at 8, taken from the shared package.
- rclk  in  1  system half-rate clock, 20 MHz (same clock as the RAM)
- rst  in  1  synchronous, active-high reset
- arm  in  1  1-cycle pulse; starts a new capture from any state
- smpl_vld  in  1  ADC sample strobe
- smpl  in  8  ADC sample
- trig  in  1  trigger event from trigger logic, level; sampled only in ARMED
- trig_pos  in  9  number of post-trigger samples, 0..511; held stable while busy
- rd_req  in  1  dump request, one sample per pulse
- en, we  out  1  RAM enable / write enable
- addr  out  9  RAM address
- wdata  out  8  RAM write data
- rdata  in  8  RAM read data
- busy  out  1  high in PRE, ARMED, POST
- cap_done  out  1  high in DONE and DUMP
- trig_addr  out  9  RAM address of the first post-trigger sample
- dump_data  out  8  sample read back
- dump_vld  out  1  1-cycle strobe qualifying dump_data
- dump_last  out  1  high with dump_vld on the 512th dumped sample

## Operation
- States: IDLE, PRE, ARMED, POST, DONE, DUMP.
- IDLE → PRE on arm. arm in any state clears all counters and enters PRE. wr_ptr is not cleared.
- Accepting samples: a smpl_vld in PRE, ARMED or POST writes smpl at wr_ptr, then wr_ptr increments mod 512, wrapping 511→0.
- PRE: counts accepted samples (10-bit counter). Moves to ARMED after 512−trig_pos samples. trig is ignored in PRE.
- ARMED: on trig=1, trig_addr is loaded with the current wr_ptr and the state moves to POST.
  - If smpl_vld is also high in that cycle, that sample is written and is the first post-trigger sample.
  - If trig_pos=0, the state moves straight to DONE and the trigger-cycle sample is not written.
- POST: counts accepted samples including the trigger-cycle sample. Moves to DONE when the count reaches trig_pos.
- DONE: rd_ptr is loaded with wr_ptr, which is the oldest sample. The first rd_req moves the state to DUMP.
- DUMP: each accepted rd_req reads rd_ptr, then rd_ptr increments mod 512.
  - Only one read may be in flight; rd_req during an outstanding read is ignored.
  - After the 512th dump_vld (dump_last=1) the state returns to IDLE.
- rd_req is ignored outside DONE/DUMP. smpl_vld is ignored in IDLE, DONE and DUMP.
- rst at any time, including mid-capture or mid-dump:
  - state IDLE; wr_ptr, rd_ptr, counters and trig_addr = 0.
  - All outputs 0. Any in-flight read is discarded with no dump_vld.

## Timing
- RAM control outputs (en, we, addr, wdata) are registered.
- Write: smpl_vld in cycle N → en=we=1 with addr/wdata in cycle N+1. The RAM commits on the rising edge that ends N+1.
- Read: rd_req in cycle N → en=1, we=0, addr=rd_ptr in N+1 → dump_vld and dump_data in N+2. Read latency is 2 cycles.
- Maximum dump rate: one sample every 2 cycles.
- State transitions happen on the edge that ends the cycle in which the qualifying sample or trig is seen. busy and cap_done follow state with no extra delay.
- Back-to-back smpl_vld every cycle is supported. Capture is never stalled.
- trig_addr is valid from the first cycle of POST until the next arm or rst.

## Configuration
- Macro: CAPTURE_DECIMATE_EN.
- Defined:
  - Adds input dec, 4 bits.
  - Only every (dec+1)-th smpl_vld is accepted. The decimation phase resets on arm.
  - PRE/POST counts and writes apply only to accepted samples.
  - dec=0 is identical to the undefined case.
- Undefined: no dec port; every smpl_vld is accepted.

## Structure
- Shared package dso_pkg holds:
  - RAM_DEPTH=512, ADDR_W=9, DATA_W=8.
  - The capture state enum cap_state_t (IDLE..DUMP).
- Sub-module dso_decimator: sample-strobe divider, instantiated only under CAPTURE_DECIMATE_EN.
- The state machine, pointers and RAM port drive stay in the top level.

## Test plan
- trig_pos=256, continuous smpl = incrementing 0x00.., trig after 300 samples → ARMED after 256 samples; DONE after 256 post-trigger samples; trig_addr=0x12C.
- Dump after capture → 512 dump_vld strobes, each 2 cycles after its rd_req. Data is oldest-first and continuous (wrapped mod 256). dump_last only on the 512th; the state then returns to IDLE.
- trig in PRE (sample 10, trig_pos=256) → ignored; trig_addr stays 0 until a trig arrives in ARMED.
- trig_pos=0 with trig and smpl_vld in the same cycle → DONE the next cycle; that sample is not written (no we pulse).
- rst asserted mid-POST and mid-DUMP → next cycle all outputs 0, state IDLE, no further dump_vld; a new arm restarts with wr_ptr=0.
- With CAPTURE_DECIMATE_EN, dec=3, smpl = 0,1,2,… → written data is 0,4,8,…

Source files
------------

// File: rtl/dso_pkg.sv
// Shared definitions for the scope capture path.
//   RAM_DEPTH : depth of the sample memory (512)
//   ADDR_W    : RAM address width (9)
//   DATA_W    : ADC sample width (8)
//   cap_state_t : capture controller state encoding
package dso_pkg;

  localparam int RAM_DEPTH = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4,
    DUMP  = 3'd5
  } cap_state_t;

endpackage

// File: rtl/dso_capture_ctrl_decimator.sv
// dso_decimator: sample-strobe divider used by the capture controller when
// CAPTURE_DECIMATE_EN is defined (the module is only compiled in that build).
// Passes every (dec+1)-th input strobe; the first strobe after clr passes.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clr     : restart the decimation phase
//   dec     : decimation factor minus one
//   in_vld  : candidate sample strobe
//   out_vld : accepted sample strobe (combinational)
`ifdef CAPTURE_DECIMATE_EN
module dso_decimator (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [3:0] dec,
  input  logic       in_vld,
  output logic       out_vld
);

  logic [3:0] phase;

  assign out_vld = in_vld && (phase == 4'd0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= 4'd0;
    end else if (in_vld) begin
      phase <= (phase == dec) ? 4'd0 : phase + 4'd1;
    end
  end

endmodule
`endif

// File: rtl/dso_capture_ctrl.sv
// dso_capture_ctrl: capture controller for the 512 x 8 sample RAM.
// Writes ADC samples into the RAM as a circular buffer with a programmable
// pre/post-trigger split, then reads the 512 samples back oldest-first.
// Optional feature macro: CAPTURE_DECIMATE_EN (adds the 4-bit dec input).
// Ports:
//   rclk, rst               : clock, synchronous active-high reset
//   arm                     : start a new capture from any state
//   smpl_vld, smpl          : ADC sample strobe and data
//   trig, trig_pos          : trigger level, post-trigger sample count
//   rd_req                  : dump request, one sample per accepted pulse
//   dec                     : decimation factor minus one (macro build only)
//   en, we, addr, wdata     : registered RAM port drive
//   rdata                   : RAM read data (valid 1 cycle after a read)
//   busy, cap_done          : capture in progress / capture complete
//   trig_addr               : RAM address of the first post-trigger sample
//   dump_data, dump_vld, dump_last : read-back stream
module dso_capture_ctrl
  import dso_pkg::*;
(
  input  logic              rclk,
  input  logic              rst,
  input  logic              arm,
  input  logic              smpl_vld,
  input  logic [DATA_W-1:0] smpl,
  input  logic              trig,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic              rd_req,
`ifdef CAPTURE_DECIMATE_EN
  input  logic [3:0]        dec,
`endif
  output logic              en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              cap_done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_vld,
  output logic              dump_last
);

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_src;
  logic [ADDR_W:0]   pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   pre_target;
  logic              capturing;
  logic              take;
  logic              wr_go;
  logic              rd_go;
  logic              rd_p1;
  logic              last_p1;

  assign capturing  = (state == PRE) || (state == ARMED) || (state == POST);
  assign busy       = capturing;
  assign cap_done   = (state == DONE) || (state == DUMP);
  assign pre_target = (ADDR_W+1)'(RAM_DEPTH) - {1'b0, trig_pos};

`ifdef CAPTURE_DECIMATE_EN
  dso_decimator u_decimator (
    .clk     (rclk),
    .rst     (rst),
    .clr     (arm),
    .dec     (dec),
    .in_vld  (smpl_vld && capturing && !arm),
    .out_vld (take)
  );
`else
  assign take = smpl_vld && capturing && !arm;
`endif

  // A zero post-trigger count ends capture on the trigger itself, so the
  // trigger-cycle sample must not land in the buffer.
  assign wr_go = take && !((state == ARMED) && trig && (trig_pos == '0));

  // In DONE the oldest sample sits at wr_ptr; the first read starts there.
  assign rd_src = (state == DONE) ? wr_ptr : rd_ptr;

  // One read in flight at a time; reads stop once all 512 have been issued.
  assign rd_go = rd_req && !rd_p1 && !arm &&
                 ((state == DONE) || ((state == DUMP) && (rd_cnt != 10'd512)));

  // Read data is only meaningful in the cycle it is qualified.
  assign dump_data = dump_vld ? rdata : '0;

  always_ff @(posedge rclk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      trig_addr <= '0;
      en        <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rd_p1     <= 1'b0;
      last_p1   <= 1'b0;
      dump_vld  <= 1'b0;
      dump_last <= 1'b0;
    end else begin
      en        <= 1'b0;
      we        <= 1'b0;
      // p1: RAM read issued this cycle; data returns in the next one
      rd_p1     <= rd_go;
      last_p1   <= rd_go && (rd_cnt == 10'd511);
      // p2: read data qualified
      dump_vld  <= rd_p1;
      dump_last <= rd_p1 && last_p1;

      if (wr_go) begin
        en     <= 1'b1;
        we     <= 1'b1;
        addr   <= wr_ptr;
        wdata  <= smpl;
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (rd_go) begin
        en     <= 1'b1;
        we     <= 1'b0;
        addr   <= rd_src;
        rd_ptr <= rd_src + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end

      if (arm) begin
        state     <= PRE;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        rd_cnt    <= '0;
        rd_p1     <= 1'b0;
        last_p1   <= 1'b0;
        dump_vld  <= 1'b0;
        dump_last <= 1'b0;
      end else begin
        case (state)
          PRE: begin
            if (take) begin
              pre_cnt <= pre_cnt + 10'd1;
              if (pre_cnt + 10'd1 == pre_target) state <= ARMED;
            end
          end
          ARMED: begin
            if (trig) begin
              trig_addr <= wr_ptr;
              if (trig_pos == '0) begin
                state <= DONE;
              end else if (take && (trig_pos == 9'd1)) begin
                state <= DONE;
              end else begin
                state    <= POST;
                post_cnt <= take ? 10'd1 : 10'd0;
              end
            end
          end
          POST: begin
            if (take) begin
              post_cnt <= post_cnt + 10'd1;
              if (post_cnt + 10'd1 == {1'b0, trig_pos}) state <= DONE;
            end
          end
          DONE: begin
            if (rd_go) state  <= DUMP;
            else       rd_ptr <= wr_ptr;
          end
          DUMP: begin
            if (dump_vld && dump_last) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Directed testbench for dso_capture_ctrl with a behavioural 512 x 8 RAM
// (synchronous write and registered read). Inputs change and outputs are
// observed on the falling clock edge. Optional macro: CAPTURE_DECIMATE_EN.
`timescale 1ns/1ps
module tb_dso_capture_ctrl;
  import dso_pkg::*;

  logic       rclk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       smpl_vld = 1'b0;
  logic [7:0] smpl = 8'h00;
  logic       trig = 1'b0;
  logic [8:0] trig_pos = 9'd0;
  logic       rd_req = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
  logic [3:0] dec = 4'd0;
`endif
  logic       en, we;
  logic [8:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata = 8'h00;
  logic       busy, cap_done;
  logic [8:0] trig_addr;
  logic [7:0] dump_data;
  logic       dump_vld, dump_last;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [512];

  always #25 rclk = ~rclk;

  always @(posedge rclk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

  dso_capture_ctrl dut (
    .rclk      (rclk),
    .rst       (rst),
    .arm       (arm),
    .smpl_vld  (smpl_vld),
    .smpl      (smpl),
    .trig      (trig),
    .trig_pos  (trig_pos),
    .rd_req    (rd_req),
`ifdef CAPTURE_DECIMATE_EN
    .dec       (dec),
`endif
    .en        (en),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .cap_done  (cap_done),
    .trig_addr (trig_addr),
    .dump_data (dump_data),
    .dump_vld  (dump_vld),
    .dump_last (dump_last)
  );

  task automatic check_all_zero(input string name);
    tests++;
    if ({en, we, addr, wdata, busy, cap_done, trig_addr, dump_data, dump_vld, dump_last} !== '0) begin
      fails++;
      $display("FAIL %s_outputs: en=%b we=%b addr=%h wdata=%h busy=%b done=%b taddr=%h ddata=%h dvld=%b dlast=%b, want all 0",
               name, en, we, addr, wdata, busy, cap_done, trig_addr, dump_data, dump_vld, dump_last);
    end
    tests++;
    if (dut.state !== IDLE) begin
      fails++;
      $display("FAIL %s_state: got %0d want %0d", name, dut.state, IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge rclk);
    check_all_zero("reset");
    rst = 1'b0;
    smpl_vld = 1'b1;
    rd_req = 1'b1;
    @(negedge rclk);
    smpl_vld = 1'b0;
    rd_req = 1'b0;
    tests++;
    if (en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: en=%b busy=%b want 0 0", en, busy);
    end
  endtask

  // trig_pos=256, trigger stray in PRE at sample 10, real trigger at sample 300
  task automatic test_capture();
    logic [8:0] ea;
    trig_pos = 9'd256;
    arm = 1'b1;
    @(negedge rclk);
    arm = 1'b0;
    tests++;
    if (busy !== 1'b1 || dut.state !== PRE) begin
      fails++;
      $display("FAIL arm_pre: busy=%b state=%0d want 1 %0d", busy, dut.state, PRE);
    end
    for (int k = 0; k < 556; k++) begin
      smpl_vld = 1'b1;
      smpl = k[7:0];
      trig = (k == 10) || (k == 300);
      @(negedge rclk);
      ea = k[8:0];
      tests++;
      if (en !== 1'b1 || we !== 1'b1 || addr !== ea || wdata !== k[7:0]) begin
        fails++;
        $display("FAIL cap_write_%0d: en=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                 k, en, we, addr, wdata, ea, k[7:0]);
      end
      if (k == 10 || k == 254) begin
        tests++;
        if (dut.state !== PRE || trig_addr !== 9'h000) begin
          fails++;
          $display("FAIL cap_pre_%0d: state=%0d taddr=%h want %0d 000", k, dut.state, trig_addr, PRE);
        end
      end
      if (k == 255 || k == 299) begin
        tests++;
        if (dut.state !== ARMED || trig_addr !== 9'h000) begin
          fails++;
          $display("FAIL cap_armed_%0d: state=%0d taddr=%h want %0d 000", k, dut.state, trig_addr, ARMED);
        end
      end
      if (k == 300 || k == 554) begin
        tests++;
        if (dut.state !== POST || trig_addr !== 9'h12C || busy !== 1'b1) begin
          fails++;
          $display("FAIL cap_post_%0d: state=%0d taddr=%h busy=%b want %0d 12c 1",
                   k, dut.state, trig_addr, busy, POST);
        end
      end
    end
    smpl_vld = 1'b0;
    trig = 1'b0;
    tests++;
    if (dut.state !== DONE || cap_done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL cap_done: state=%0d done=%b busy=%b want %0d 1 0", dut.state, cap_done, busy, DONE);
    end
  endtask

  // Oldest sample is 44 (556 samples written); read at full rate, some
  // requests held over the in-flight cycle to confirm they are ignored.
  task automatic test_dump();
    logic [8:0] ea;
    logic [7:0] ed;
    for (int i = 0; i < 512; i++) begin
      ea = 9'(44 + i);
      ed = 8'(44 + i);
      rd_req = 1'b1;
      @(negedge rclk);
      rd_req = ((i % 64) == 5);
      tests++;
      if (en !== 1'b1 || we !== 1'b0 || addr !== ea || dump_vld !== 1'b0) begin
        fails++;
        $display("FAIL dump_read_%0d: en=%b we=%b addr=%h dvld=%b want 1 0 %h 0", i, en, we, addr, dump_vld, ea);
      end
      @(negedge rclk);
      rd_req = 1'b0;
      tests++;
      if (dump_vld !== 1'b1 || dump_data !== ed || dump_last !== (i == 511) || en !== 1'b0) begin
        fails++;
        $display("FAIL dump_data_%0d: dvld=%b data=%h last=%b en=%b want 1 %h %b 0",
                 i, dump_vld, dump_data, dump_last, en, ed, (i == 511));
      end
    end
    @(negedge rclk);
    tests++;
    if (dut.state !== IDLE || cap_done !== 1'b0 || dump_vld !== 1'b0) begin
      fails++;
      $display("FAIL dump_end: state=%0d done=%b dvld=%b want %0d 0 0", dut.state, cap_done, dump_vld, IDLE);
    end
  endtask

  // trig_pos=0: trigger with a sample in the same cycle ends capture unwritten
  task automatic test_trig_pos0();
    trig_pos = 9'd0;
    arm = 1'b1;
    @(negedge rclk);
    arm = 1'b0;
    for (int k = 0; k < 512; k++) begin
      smpl_vld = 1'b1;
      smpl = k[7:0];
      @(negedge rclk);
      if (k == 510) begin
        tests++;
        if (dut.state !== PRE) begin
          fails++;
          $display("FAIL tp0_pre: state=%0d want %0d", dut.state, PRE);
        end
      end
    end
    tests++;
    if (dut.state !== ARMED) begin
      fails++;
      $display("FAIL tp0_armed: state=%0d want %0d", dut.state, ARMED);
    end
    smpl = 8'hAA;
    trig = 1'b1;
    @(negedge rclk);
    smpl_vld = 1'b0;
    trig = 1'b0;
    tests++;
    if (dut.state !== DONE || en !== 1'b0 || we !== 1'b0 || cap_done !== 1'b1 || trig_addr !== 9'd44) begin
      fails++;
      $display("FAIL tp0_done: state=%0d en=%b we=%b done=%b taddr=%h want %0d 0 0 1 02c",
               dut.state, en, we, cap_done, trig_addr, DONE);
    end
  endtask

  task automatic test_reset_mid();
    // reset in POST
    trig_pos = 9'd256;
    arm = 1'b1;
    @(negedge rclk);
    arm = 1'b0;
    for (int k = 0; k < 290; k++) begin
      smpl_vld = 1'b1;
      smpl = k[7:0];
      trig = (k == 280);
      @(negedge rclk);
    end
    smpl_vld = 1'b0;
    trig = 1'b0;
    tests++;
    if (dut.state !== POST) begin
      fails++;
      $display("FAIL rpost_setup: state=%0d want %0d", dut.state, POST);
    end
    rst = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    check_all_zero("rst_post");
    // restart: write pointer starts again from 0
    trig_pos = 9'd4;
    arm = 1'b1;
    @(negedge rclk);
    arm = 1'b0;
    for (int k = 0; k < 512; k++) begin
      smpl_vld = 1'b1;
      smpl = 8'(k + 128);
      trig = (k == 508);
      @(negedge rclk);
      if (k == 0) begin
        tests++;
        if (en !== 1'b1 || we !== 1'b1 || addr !== 9'd0 || wdata !== 8'h80) begin
          fails++;
          $display("FAIL restart_write: en=%b we=%b addr=%h wdata=%h want 1 1 000 80", en, we, addr, wdata);
        end
      end
    end
    smpl_vld = 1'b0;
    trig = 1'b0;
    tests++;
    if (dut.state !== DONE || trig_addr !== 9'h1FC) begin
      fails++;
      $display("FAIL restart_done: state=%0d taddr=%h want %0d 1fc", dut.state, trig_addr, DONE);
    end
    // one complete read, then reset with the second read in flight
    rd_req = 1'b1;
    @(negedge rclk);
    rd_req = 1'b0;
    @(negedge rclk);
    tests++;
    if (dump_vld !== 1'b1 || dump_data !== 8'h80) begin
      fails++;
      $display("FAIL rdump_first: dvld=%b data=%h want 1 80", dump_vld, dump_data);
    end
    rd_req = 1'b1;
    @(negedge rclk);
    rd_req = 1'b0;
    rst = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    check_all_zero("rst_dump");
    for (int c = 0; c < 4; c++) begin
      @(negedge rclk);
      tests++;
      if (dump_vld !== 1'b0) begin
        fails++;
        $display("FAIL rst_dump_novld_%0d: dvld=%b want 0", c, dump_vld);
      end
    end
  endtask

`ifdef CAPTURE_DECIMATE_EN
  task automatic test_decimate();
    logic exp_wr;
    logic [8:0] ea;
    rst = 1'b1;
    @(negedge rclk);
    rst = 1'b0;
    dec = 4'd3;
    trig_pos = 9'd256;
    arm = 1'b1;
    @(negedge rclk);
    arm = 1'b0;
    for (int k = 0; k < 16; k++) begin
      smpl_vld = 1'b1;
      smpl = k[7:0];
      @(negedge rclk);
      exp_wr = ((k % 4) == 0);
      ea = 9'(k / 4);
      tests++;
      if (en !== exp_wr || (exp_wr && (addr !== ea || wdata !== k[7:0]))) begin
        fails++;
        $display("FAIL dec_write_%0d: en=%b addr=%h wdata=%h want %b %h %h", k, en, addr, wdata, exp_wr, ea, k[7:0]);
      end
    end
    smpl_vld = 1'b0;
    dec = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_dump();
    test_trig_pos0();
    test_reset_mid();
`ifdef CAPTURE_DECIMATE_EN
    test_decimate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
